// File: rtl/batch_1_sdiv_seq_35s_9u.sv
// -----------------------------------------------------------------------------
// batch_1_sdiv_seq_35s_9u
// Sequential signed-by-unsigned divider. It is the inverse of a signed-26 x
// unsigned-9 multiplier. A 35-bit two's-complement dividend is divided by a
// 9-bit unsigned divisor, one quotient bit per cycle (restoring shift-subtract,
// MSB first). The quotient truncates toward zero. The remainder takes the sign
// of the dividend.
//
// Ports
//   ap_clk   in   1   sole clock, rising edge
//   ap_rst   in   1   synchronous active-high reset
//   ap_start in   1   request, only looked at while idle
//   din0     in  35   signed dividend
//   din1     in   9   unsigned divisor
//   ap_idle  out  1   high only while idle
//   ap_done  out  1   one-cycle pulse; result outputs are valid
//   ap_ready out  1   same as ap_done
//   dout     out 26   signed quotient (saturated on overflow / divide by zero)
//   rem      out 10   signed remainder
//   ovf      out  1   quotient saturated
//   dbz      out  1   divisor was zero
//
// Timing: the edge that accepts ap_start loads the operands. The next 35 edges
// each produce one quotient bit. The last of those edges also applies sign
// correction and raises ap_done, so the edge 36 after acceptance samples
// ap_done high. One idle cycle then follows before the next acceptance.
// -----------------------------------------------------------------------------
module batch_1_sdiv_seq_35s_9u #(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned din0_WIDTH = 32'd35,
  parameter int unsigned din1_WIDTH = 32'd9,
  parameter int unsigned dout_WIDTH = 32'd26
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    ap_start,
  input  logic [din0_WIDTH-1:0]   din0,
  input  logic [din1_WIDTH-1:0]   din1,
  output logic                    ap_idle,
  output logic                    ap_done,
  output logic                    ap_ready,
  output logic [dout_WIDTH-1:0]   dout,
  output logic [din1_WIDTH:0]     rem,
  output logic                    ovf,
  output logic                    dbz
);

  localparam int unsigned DW = din0_WIDTH;
  localparam int unsigned VW = din1_WIDTH;
  localparam int unsigned QW = dout_WIDTH;
  localparam int unsigned RW = din1_WIDTH + 32'd1;

  // Largest legal unsigned quotient magnitude for positive / negative results
  localparam logic [DW-1:0] POS_LIM = {{(DW-QW+1){1'b0}}, {(QW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_LIM = {{(DW-QW){1'b0}}, 1'b1, {(QW-1){1'b0}}};
  localparam logic [QW-1:0] SAT_POS = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] SAT_NEG = {1'b1, {(QW-1){1'b0}}};
  localparam logic [5:0]    CNT_TOP = 6'(DW - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [5:0]      cnt_r;
  logic [DW-1:0]   dvd_r;    // dividend magnitude shifting out, quotient shifting in
  logic [RW-1:0]   prem_r;   // partial remainder
  logic [VW-1:0]   div_r;
  logic            neg_r;

  logic [RW-1:0]   shift_s;
  logic            ge_s;
  logic [RW-1:0]   prem_nxt_s;
  logic [DW-1:0]   quo_nxt_s;
  logic [QW-1:0]   fin_q_s;
  logic [RW-1:0]   fin_r_s;
  logic            fin_ovf_s;
  logic            fin_dbz_s;

  // Magnitude of a two's-complement value. The most negative input maps to
  // 2^(DW-1), which still fits as an unsigned DW-bit number.
  function automatic logic [din0_WIDTH-1:0] abs_fn(input logic [din0_WIDTH-1:0] v);
    logic [din0_WIDTH-1:0] m;
    if (v[din0_WIDTH-1]) begin
      m = '0 - v;
    end else begin
      m = v;
    end
    return m;
  endfunction

  assign ap_ready = ap_done;

  // One restoring shift-subtract step on the current partial remainder
  always_comb begin
    shift_s    = {prem_r[RW-2:0], dvd_r[DW-1]};
    ge_s       = (shift_s >= {1'b0, div_r});
    prem_nxt_s = shift_s;
    if (ge_s) begin
      prem_nxt_s = shift_s - {1'b0, div_r};
    end else begin
      prem_nxt_s = shift_s;
    end
    quo_nxt_s  = {dvd_r[DW-2:0], ge_s};
  end

  // Final result from the last step: saturation, divide by zero, sign correction
  always_comb begin
    fin_q_s   = SAT_POS;
    fin_r_s   = '0;
    fin_ovf_s = 1'b0;
    fin_dbz_s = 1'b0;
    if (div_r == '0) begin
      fin_dbz_s = 1'b1;
      fin_q_s   = neg_r ? SAT_NEG : SAT_POS;
    end else if (neg_r ? (quo_nxt_s > NEG_LIM) : (quo_nxt_s > POS_LIM)) begin
      fin_ovf_s = 1'b1;
      fin_q_s   = neg_r ? SAT_NEG : SAT_POS;
    end else if (neg_r) begin
      fin_q_s   = '0 - quo_nxt_s[QW-1:0];
      fin_r_s   = '0 - prem_nxt_s;
    end else begin
      fin_q_s   = quo_nxt_s[QW-1:0];
      fin_r_s   = prem_nxt_s;
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r <= S_IDLE;
      cnt_r   <= 6'd0;
      dvd_r   <= '0;
      prem_r  <= '0;
      div_r   <= '0;
      neg_r   <= 1'b0;
      ap_idle <= 1'b1;
      ap_done <= 1'b0;
      dout    <= '0;
      rem     <= '0;
      ovf     <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          ap_done <= 1'b0;
          if (ap_start) begin
            dvd_r   <= abs_fn(din0);
            neg_r   <= din0[DW-1];
            div_r   <= din1;
            prem_r  <= '0;
            cnt_r   <= CNT_TOP;
            ap_idle <= 1'b0;
            state_r <= S_CALC;
          end else begin
            ap_idle <= 1'b1;
          end
        end
        S_CALC: begin
          dvd_r  <= quo_nxt_s;
          prem_r <= prem_nxt_s;
          if (cnt_r == 6'd0) begin
            dout    <= fin_q_s;
            rem     <= fin_r_s;
            ovf     <= fin_ovf_s;
            dbz     <= fin_dbz_s;
            ap_done <= 1'b1;
            state_r <= S_DONE;
          end else begin
            cnt_r <= cnt_r - 6'd1;
          end
        end
        S_DONE: begin
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
          state_r <= S_IDLE;
        end
        default: begin
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_batch_1_sdiv_seq_35s_9u.sv
// Scoreboard bench: the driver pushes the expected result, computed with
// plain integer division, and the predicted acceptance edge. The monitor
// pops one entry at every ap_done and compares it.
module tb_batch_1_sdiv_seq_35s_9u;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ap_start = 1'b0;
  logic [34:0] din0 = 35'd0;
  logic [8:0]  din1 = 9'd0;
  logic        ap_idle, ap_done, ap_ready, ovf, dbz;
  logic [25:0] dout;
  logic [9:0]  rem;

  typedef struct {
    logic [34:0] a;
    logic [8:0]  b;
    logic [25:0] q;
    logic [9:0]  r;
    logic        ovf;
    logic        dbz;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  batch_1_sdiv_seq_35s_9u dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .din0(din0), .din1(din1),
    .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
    .dout(dout), .rem(rem), .ovf(ovf), .dbz(dbz)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, %0d expected results outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Reference: truncating integer division with saturation rules
  function automatic exp_t model(input logic [34:0] a_bits, input logic [8:0] b_bits);
    exp_t   e;
    longint a, b, qq, rr;
    a = longint'($signed(a_bits));
    b = longint'(b_bits);
    e.a = a_bits; e.b = b_bits; e.ovf = 1'b0; e.dbz = 1'b0; e.acc = 0;
    if (b == 0) begin
      e.dbz = 1'b1;
      e.q = (a < 0) ? 26'h2000000 : 26'h1FFFFFF;
      e.r = 10'd0;
    end else begin
      qq = a / b;
      rr = a % b;
      if (qq > 64'sd33554431 || qq < -64'sd33554432) begin
        e.ovf = 1'b1;
        e.q = (a < 0) ? 26'h2000000 : 26'h1FFFFFF;
        e.r = 10'd0;
      end else begin
        e.q = qq[25:0];
        e.r = rr[9:0];
      end
    end
    return e;
  endfunction

  // Monitor: compare each ap_done pulse against the oldest expected entry.
  // The edge 36 after acceptance samples ap_done, so the negedge just before
  // that edge sees cyc == acc + 35.
  always @(negedge ap_clk) begin
    if (!ap_rst && ap_done) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_done: ap_done=1 at cycle %0d with no operation outstanding (required 0)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (dout !== e.q || rem !== e.r || ovf !== e.ovf || dbz !== e.dbz ||
            ap_ready !== 1'b1 || (cyc - e.acc) != 35) begin
          n_bad++;
          $display("FAIL result: din0=%0d din1=%0d got dout=%0d rem=%0d ovf=%b dbz=%b rdy=%b lat=%0d required dout=%0d rem=%0d ovf=%b dbz=%b rdy=1 lat=35",
                   $signed(e.a), e.b, $signed(dout), $signed(rem), ovf, dbz, ap_ready, cyc - e.acc,
                   $signed(e.q), $signed(e.r), e.ovf, e.dbz);
        end
      end
    end
  end

  task automatic check_reset_state(input string name);
    n_vec++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0 || dout !== 26'd0 ||
        rem !== 10'd0 || ovf !== 1'b0 || dbz !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: idle=%b done=%b rdy=%b dout=%0d rem=%0d ovf=%b dbz=%b required idle=1 and all others 0",
               name, ap_idle, ap_done, ap_ready, dout, rem, ovf, dbz);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge ap_clk);
    while (ap_idle !== 1'b1 && k < 100) begin
      @(negedge ap_clk);
      k++;
    end
    if (ap_idle !== 1'b1) begin
      n_vec++; n_bad++;
      $display("FAIL idle_timeout: ap_idle=%b required 1 within 100 cycles", ap_idle);
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge ap_clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL done_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Single operation: issue, scramble inputs, optional stray start in CALC
  task automatic run_op(input logic [34:0] a, input logic [8:0] b);
    exp_t e;
    int   stray;
    wait_idle();
    din0 = a; din1 = b; ap_start = 1'b1;
    e = model(a, b);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge ap_clk);
    ap_start = 1'b0;
    din0 = {$urandom, $urandom};
    din1 = 9'($urandom);
    stray = $urandom_range(3, 30);
    repeat (stray) @(negedge ap_clk);
    ap_start = ($urandom_range(0, 1) == 1);
    @(negedge ap_clk);
    ap_start = 1'b0;
    wait_drain();
  endtask

  function automatic logic [34:0] rand_a(input logic [8:0] b);
    logic [63:0] t;
    longint      base, v;
    t = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: return t[34:0];
      1: return {{5{t[29]}}, t[29:0]};
      2: return {{25{t[9]}}, t[9:0]};
      default: begin
        base = longint'(b) * 64'sd33554432;
        v = base - 64'sd1 + longint'($urandom_range(0, 4)) - 64'sd2;
        if (t[40]) v = -v;
        return v[34:0];
      end
    endcase
  endfunction

  function automatic logic [8:0] rand_b();
    case ($urandom_range(0, 7))
      0: return 9'd0;
      1: return 9'd1;
      2: return 9'd255;
      default: return 9'($urandom);
    endcase
  endfunction

  initial begin
    exp_t e;
    logic [8:0] b;
    // Reset state
    repeat (3) @(negedge ap_clk);
    check_reset_state("reset_state");
    ap_rst = 1'b0;

    // Directed cases
    run_op(35'd1000, 9'd7);
    run_op(-35'sd1000, 9'd7);
    run_op(-35'sd7, 9'd255);
    run_op(35'd5, 9'd0);
    run_op(-35'sd5, 9'd0);
    run_op(35'd17179869183, 9'd1);
    run_op(-35'sd17179869184, 9'd255);
    run_op(35'd33554431, 9'd1);
    run_op(-35'sd33554432, 9'd1);
    run_op(-35'sd33554433, 9'd1);
    run_op(35'd33554432, 9'd1);
    run_op(-35'sd17179869184, 9'd1);
    run_op(35'd0, 9'd3);
    run_op(35'd8556380415, 9'd255);

    // Reset while busy: aborted job never reports; start with reset is ignored
    wait_idle();
    din0 = 35'd123456; din1 = 9'd11; ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (4) @(negedge ap_clk);
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b1; ap_start = 1'b1;
    @(negedge ap_clk);
    check_reset_state("abort_reset");
    ap_rst = 1'b0; ap_start = 1'b0;
    @(negedge ap_clk);
    check_reset_state("start_with_reset_ignored");
    repeat (40) @(negedge ap_clk);
    run_op(35'd1000, 9'd7);

    // Randomized single operations
    for (int i = 0; i < 500; i++) begin
      b = rand_b();
      run_op(rand_a(b), b);
    end

    // ap_start held high: a new acceptance every 37 cycles, inputs scrambled between
    wait_idle();
    ap_start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b = rand_b();
      din1 = b;
      din0 = rand_a(b);
      e = model(din0, din1);
      e.acc = cyc + 1;
      exp_q.push_back(e);
      for (int j = 0; j < 36; j++) begin
        @(negedge ap_clk);
        if (i == 39 && j == 0) ap_start = 1'b0;
        din0 = {$urandom, $urandom};
        din1 = 9'($urandom);
      end
      if (i != 39) @(negedge ap_clk);
    end
    wait_drain();
    repeat (5) @(negedge ap_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/batch_1_sdiv_seq_35s_9u.md
BATCH_1_SDIV_SEQ_35S_9U -- requirements
Module: batch_1_sdiv_seq_35s_9u

Interface
REQ-001 Parameter ID, default 32'd1, instance identifier; no functional effect.
REQ-002 Parameter din0_WIDTH, default 32'd35, dividend width; block SHALL be correct for the value 35.
REQ-003 Parameter din1_WIDTH, default 32'd9, divisor width; block SHALL be correct for the value 9.
REQ-004 Parameter dout_WIDTH, default 32'd26, quotient width; block SHALL be correct for the value 26.
REQ-005 Clocking SHALL be exactly as decided: one clock; reset is synchronous and active-high.
REQ-006 ap_clk  in  1  sole clock; all state changes on rising edge.
REQ-007 ap_rst  in  1  synchronous active-high reset.
REQ-008 ap_start  in  1  request; sampled only in IDLE.
REQ-009 din0  in  35  signed dividend; two's complement.
REQ-010 din1  in  9  unsigned divisor.
REQ-011 ap_idle  out  1  high only in IDLE.
REQ-012 ap_done  out  1  one-cycle pulse; outputs valid.
REQ-013 ap_ready  out  1  equal to ap_done.
REQ-014 dout  out  26  signed quotient.
REQ-015 rem  out  10  signed remainder.
REQ-016 ovf  out  1  quotient saturated.
REQ-017 dbz  out  1  divisor was zero.

Function
REQ-018 Block SHALL be the inverse operator of the signed-26 x unsigned-9 multiplier: dout = trunc(din0 / din1) toward zero.
REQ-019 rem SHALL carry the sign of din0, with |rem| < din1 and din0 = dout*din1 + rem whenever ovf=0 and dbz=0.
REQ-020 FSM SHALL have states IDLE, CALC, DONE; IDLE->CALC on ap_start=1; CALC->DONE after 35 iterations; DONE->IDLE unconditionally after 1 cycle.
REQ-021 On the accepting edge, the block SHALL latch |din0| as a 35-bit unsigned value, the sign of din0 and din1; later input changes SHALL have no effect.
REQ-022 |-2^34| = 2^34 SHALL be handled without loss.
REQ-023 CALC SHALL perform a restoring shift-subtract of one quotient bit per cycle, MSB first, using a 10-bit partial remainder; a 6-bit counter SHALL count 34 down to 0.
REQ-024 ap_done SHALL be high exactly 36 cycles after the edge that samples ap_start, for exactly one cycle.
REQ-025 dout, rem, ovf and dbz SHALL be registered, updated on entry to DONE, and held until the next DONE or reset.
REQ-026 Sign correction SHALL be applied on the DONE transition: negate quotient and remainder if din0 < 0.
REQ-027 Overflow: if the unsigned 35-bit quotient exceeds 2^25-1 (positive) or 2^25 (negative), dout SHALL saturate to 33554431 or -33554432, ovf=1 and rem=0.
REQ-028 Divide by zero: if din1 = 0, the block SHALL still take 36 cycles, dbz=1, ovf=0, rem=0 and dout=33554431 (din0 >= 0) or -33554432 (din0 < 0).
REQ-029 ap_start in CALC or DONE SHALL be ignored, with no queuing; back-to-back operations SHALL be separated by at least 1 IDLE cycle.
REQ-030 ap_start held high SHALL start a new operation on the first IDLE edge.

Reset
REQ-031 When ap_rst=1 at an edge, state SHALL become IDLE and ap_idle=1; ap_done, ap_ready, dout, rem, ovf and dbz SHALL all be 0.
REQ-032 Reset in CALC or DONE SHALL abort the operation; no ap_done pulse SHALL occur for the aborted operation.
REQ-033 ap_start together with ap_rst SHALL be ignored; reset has priority.

Verification
REQ-034 din0=1000, din1=7, start at edge k -> ap_done at k+36: dout=142, rem=6, ovf=0, dbz=0.
REQ-035 din0=-1000, din1=7 -> dout=-142, rem=-6; din0=-7, din1=255 -> dout=0, rem=-7.
REQ-036 din0=5, din1=0 -> dbz=1, dout=33554431, rem=0; din0=-5, din1=0 -> dout=-33554432.
REQ-037 din0=17179869183, din1=1 -> ovf=1, dout=33554431; din0=-17179869184, din1=255 -> ovf=1, dout=-33554432; din0=33554431, din1=1 -> ovf=0.
REQ-038 Start a job; pulse ap_start again at cycle 5; assert ap_rst at cycle 10 -> no ap_done, all outputs 0, ap_idle=1 next cycle; a new start then completes in 36 cycles.
REQ-039 Randomized 10^5 operands checked against a reference model; ap_start held high continuously -> one ap_done every 37 cycles.
